// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding for the serial
// arithmetic units and the default Hack word width.
package arith_pkg;

  localparam int HACK_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = arith_pkg::HACK_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per cycle LSB first, through a
// single full-subtractor cell with a registered borrow. The result registers
// update only when an operation completes and hold until the next completion.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic             load;
  logic             shift;
  logic             finish;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             bw;
  logic [CNT_W-1:0] cnt;

  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath control; start is only looked at in IDLE.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          next_state = S_RUN;
          load       = 1'b1;
        end
      end
      S_RUN: begin
        shift = 1'b1;
        if (cnt == CNT_LAST) begin
          next_state = S_DONE;
          finish     = 1'b1;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand/result shift registers, borrow flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      sa  <= bus.a;
      sb  <= bus.b;
      sr  <= '0;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (shift) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {cell_d, sr[WIDTH-1:1]};
      bw  <= cell_bout;
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers capture the last bit together with the shifted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
    end else if (finish) begin
      bus.diff   <= {cell_d, sr[WIDTH-1:1]};
      bus.borrow <= cell_bout;
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table and multi-cycle corner
// sequences at WIDTH=16, plus random sweeps at WIDTH=8 and WIDTH=2 checked
// against plain integer arithmetic.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(16)) bus16 ();
  serial_subtractor_if #(.WIDTH(8))  bus8  ();
  serial_subtractor_if #(.WIDTH(2))  bus2  ();

  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bo;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One WIDTH=16 operation; cyc counts cycles after the accepting edge
  // (cycle 1 is the one right after it) until done is seen.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v,
                      output logic [15:0] d, output logic bo, output int cyc);
    @(negedge clk);
    bus16.a     = ta;
    bus16.b     = tb_v;
    bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
    check("w16 busy in run", 32'(bus16.busy), 32'd1);
    cyc = 1;
    while (!bus16.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    d  = bus16.diff;
    bo = bus16.borrow;
  endtask

  task automatic sweep8();
    logic [7:0] ta, tb_v;
    int e, cyc;
    for (int i = 0; i < 1000; i++) begin
      ta = 8'($urandom);
      tb_v = 8'($urandom);
      if (i == 0) begin ta = 8'h00; tb_v = 8'hFF; end
      if (i == 1) begin ta = 8'hFF; tb_v = 8'hFF; end
      @(negedge clk);
      bus8.a = ta; bus8.b = tb_v; bus8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      cyc = 1;
      while (!bus8.done && cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
      e = int'(ta) - int'(tb_v);
      if (e < 0) e += 256;
      check("w8 latency", 32'(cyc), 32'd9);
      check("w8 diff", 32'(bus8.diff), 32'(e));
      check("w8 borrow", 32'(bus8.borrow), 32'(ta < tb_v));
    end
  endtask

  task automatic sweep2();
    logic [1:0] ta, tb_v;
    int e, cyc;
    for (int i = 0; i < 1000; i++) begin
      ta = 2'($urandom);
      tb_v = 2'($urandom);
      @(negedge clk);
      bus2.a = ta; bus2.b = tb_v; bus2.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus2.start = 1'b0;
      bus2.a = 2'($urandom); bus2.b = 2'($urandom);
      cyc = 1;
      while (!bus2.done && cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
      e = int'(ta) - int'(tb_v);
      if (e < 0) e += 4;
      check("w2 latency", 32'(cyc), 32'd3);
      check("w2 diff", 32'(bus2.diff), 32'(e));
      check("w2 borrow", 32'(bus2.borrow), 32'(ta < tb_v));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        bo;
    int          cyc;
    int          ndone;
    int          done_cyc [2];
    logic [15:0] done_diff [2];

    vecs[0] = '{a: 16'd5,     b: 16'd3,     d: 16'h0002, bo: 1'b0};
    vecs[1] = '{a: 16'd3,     b: 16'd5,     d: 16'hFFFE, bo: 1'b1};
    vecs[2] = '{a: 16'h8000,  b: 16'd1,     d: 16'h7FFF, bo: 1'b0};
    vecs[3] = '{a: 16'hFFFF,  b: 16'hFFFF,  d: 16'h0000, bo: 1'b0};
    vecs[4] = '{a: 16'h0000,  b: 16'hFFFF,  d: 16'h0001, bo: 1'b1};

    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    bus2.start  = 1'b0; bus2.a  = '0; bus2.b  = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus16.busy), 32'd0);
    check("reset done", 32'(bus16.done), 32'd0);
    check("reset diff", 32'(bus16.diff), 32'd0);
    check("reset borrow", 32'(bus16.borrow), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      op16(vecs[i].a, vecs[i].b, d, bo, cyc);
      check($sformatf("vec%0d latency", i), 32'(cyc), 32'd17);
      check($sformatf("vec%0d diff", i), 32'(d), 32'(vecs[i].d));
      check($sformatf("vec%0d borrow", i), 32'(bo), 32'(vecs[i].bo));
    end

    // 7-2 with a second start (9-1) issued four cycles into RUN.
    @(negedge clk);
    bus16.a = 16'd7; bus16.b = 16'd2; bus16.start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus16.start = 1'b0;
        check("diff held in run", 32'(bus16.diff), 32'h0001);
      end
      if (c == 4) begin bus16.a = 16'd9; bus16.b = 16'd1; bus16.start = 1'b1; end
      if (c == 5) bus16.start = 1'b0;
      if (bus16.done) begin
        if (ndone < 2) begin done_cyc[ndone] = c; done_diff[ndone] = bus16.diff; end
        ndone++;
      end
    end
    check("busy-start done count", 32'(ndone), 32'd1);
    if (ndone >= 1) begin
      check("busy-start latency", 32'(done_cyc[0]), 32'd17);
      check("busy-start diff", 32'(done_diff[0]), 32'h0005);
    end

    // start held high: 20-5 first, operands then changed to 100-1. start is
    // only sampled in IDLE, so the second accept lands one edge after DONE
    // hands back to IDLE (cycle 18 after the first accept).
    @(negedge clk);
    bus16.a = 16'd20; bus16.b = 16'd5; bus16.start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 1) begin bus16.a = 16'd100; bus16.b = 16'd1; end
      if (c == 19) bus16.start = 1'b0;
      if (bus16.done) begin
        if (ndone < 2) begin done_cyc[ndone] = c; done_diff[ndone] = bus16.diff; end
        ndone++;
      end
    end
    check("held-start done count", 32'(ndone), 32'd2);
    if (ndone >= 2) begin
      check("held-start first at", 32'(done_cyc[0]), 32'd17);
      check("held-start first diff", 32'(done_diff[0]), 32'd15);
      check("held-start second at", 32'(done_cyc[1]), 32'd35);
      check("held-start second diff", 32'(done_diff[1]), 32'd99);
    end

    // Reset pulse 8 cycles into RUN of 50-8.
    @(negedge clk);
    bus16.a = 16'd50; bus16.b = 16'd8; bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-run reset busy", 32'(bus16.busy), 32'd0);
    check("mid-run reset done", 32'(bus16.done), 32'd0);
    check("mid-run reset diff", 32'(bus16.diff), 32'd0);
    check("mid-run reset borrow", 32'(bus16.borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (bus16.done) ndone++;
    end
    check("no done after reset", 32'(ndone), 32'd0);
    op16(16'd10, 16'd4, d, bo, cyc);
    check("post-reset latency", 32'(cyc), 32'd17);
    check("post-reset diff", 32'(d), 32'h0006);
    check("post-reset borrow", 32'(bo), 32'd0);

    fork
      sweep8();
      sweep2();
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
